// File: rtl/sub_share_ctrl.sv
// Shares one 32-bit subtractor between the ALU SUB/CMP path (id 0) and the
// branch-compare path (id 1), and holds each {N,Z,C,V,diff} result until it is consumed.
module sub_share_ctrl #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic [31:0] sub_in1,
    output logic [31:0] sub_in2,
    output logic        sub_en,
    input  logic [35:0] sub_out,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [35:0] rsp_data,
    input  logic        rsp_ready
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        cur_id_q, cur_id_d;
    logic        last_grant_q, last_grant_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [35:0] rsp_data_q, rsp_data_d;
    logic        grant_id;
    logic        accept;

    // Round-robin only matters when both requesters are pending at once.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    assign sub_in1   = op_a_q;
    assign sub_in2   = op_b_q;
    assign sub_en    = (state_q == EXEC);
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        cur_id_d     = cur_id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d   = grant_id ? req1_a : req0_a;
                    op_b_d   = grant_id ? req1_b : req0_b;
                    cur_id_d = grant_id;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // sub_out is only trusted here; it floats in every other state.
                rsp_data_d   = sub_out;
                rsp_id_d     = cur_id_q;
                rsp_valid_d  = 1'b1;
                last_grant_d = cur_id_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q      <= IDLE;
            op_a_q       <= 32'h0;
            op_b_q       <= 32'h0;
            cur_id_q     <= 1'b0;
            last_grant_q <= ~PRIO_INIT;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= 36'h0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            cur_id_q     <= cur_id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_sub_share_ctrl.sv
// Bench for sub_share_ctrl: directed requests with hand-computed results, a
// behavioural subtractor on the datapath side, and a queue-based response scoreboard.
module tb_sub_share_ctrl;

    logic        clock;
    logic        clear;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic [31:0] sub_in1;
    logic [31:0] sub_in2;
    logic        sub_en;
    logic [35:0] sub_out;
    logic        rsp_valid;
    logic        rsp_id;
    logic [35:0] rsp_data;
    logic        rsp_ready;

    logic        modelC;
    logic [31:0] mDiff;
    logic        mV;

    int testsRun;
    int testsFailed;
    int monTests;
    int monFailed;

    logic [36:0] expQ[$];

    sub_share_ctrl #(.PRIO_INIT(1'b0)) dut (
        .clock      (clock),
        .clear      (clear),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .sub_in1    (sub_in1),
        .sub_in2    (sub_in2),
        .sub_en     (sub_en),
        .sub_out    (sub_out),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural subtractor; its carry convention is supplied by the bench per vector.
    always_comb begin
        mDiff   = sub_in1 - sub_in2;
        mV      = (sub_in1[31] != sub_in2[31]) && (mDiff[31] != sub_in1[31]);
        sub_out = 36'hz;
        if (sub_en) begin
            sub_out = {mDiff[31], (mDiff == 32'h0), modelC, mV, mDiff};
        end
    end

    // Scoreboard monitor: compares each response on the cycle it is consumed.
    initial begin
        monTests  = 0;
        monFailed = 0;
    end

    always @(negedge clock) begin
        if (clear && rsp_valid && rsp_ready) begin
            monTests = monTests + 1;
            if (expQ.size() == 0) begin
                monFailed = monFailed + 1;
                $display("[TB] FAIL rsp unexpected: got id=%0d data=%h, none expected", rsp_id, rsp_data);
            end else begin
                logic [36:0] exp;
                exp = expQ.pop_front();
                if ({rsp_id, rsp_data} !== exp) begin
                    monFailed = monFailed + 1;
                    $display("[TB] FAIL rsp: got id=%0d data=%h, expected id=%0d data=%h",
                             rsp_id, rsp_data, exp[36], exp[35:0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun = testsRun + 1;
        if (act !== exp) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic driveReq(input logic id, input logic [31:0] a, input logic [31:0] b);
        if (id == 1'b0) begin
            req0_valid = 1'b1;
            req0_a     = a;
            req0_b     = b;
        end else begin
            req1_valid = 1'b1;
            req1_a     = a;
            req1_b     = b;
        end
    endtask

    task automatic applyStimulus(input logic id, input logic [31:0] a, input logic [31:0] b,
                                 input logic [35:0] expData);
        @(posedge clock);
        #1;
        driveReq(id, a, b);
        rsp_ready = 1'b1;
        @(negedge clock);
        checkOutput("grant", {62'h0, req1_ready, req0_ready}, id ? 64'h2 : 64'h1);
        expQ.push_back({id, expData});
        @(posedge clock);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clock);
        checkOutput("exec sub_en", {63'h0, sub_en}, 64'h1);
        checkOutput("exec sub_in1", {32'h0, sub_in1}, {32'h0, a});
        checkOutput("exec sub_in2", {32'h0, sub_in2}, {32'h0, b});
        checkOutput("exec rsp_valid", {63'h0, rsp_valid}, 64'h0);
        checkOutput("exec ready", {62'h0, req1_ready, req0_ready}, 64'h0);
        @(negedge clock);
        checkOutput("resp sub_en", {63'h0, sub_en}, 64'h0);
        checkOutput("resp rsp_valid", {63'h0, rsp_valid}, 64'h1);
        @(negedge clock);
        checkOutput("idle rsp_valid", {63'h0, rsp_valid}, 64'h0);
    endtask

    task automatic applyReset();
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
    endtask

    initial begin
        int grants;
        int lastCycle;
        int waitCycles;
        testsRun    = 0;
        testsFailed = 0;
        modelC      = 1'b0;
        clear       = 1'b0;
        req0_valid  = 1'b0;
        req0_a      = 32'h0;
        req0_b      = 32'h0;
        req1_valid  = 1'b0;
        req1_a      = 32'h0;
        req1_b      = 32'h0;
        rsp_ready   = 1'b0;

        #3;
        checkOutput("reset rsp_valid", {63'h0, rsp_valid}, 64'h0);
        checkOutput("reset rsp_id", {63'h0, rsp_id}, 64'h0);
        checkOutput("reset rsp_data", {28'h0, rsp_data}, 64'h0);
        checkOutput("reset sub_en", {63'h0, sub_en}, 64'h0);
        checkOutput("reset sub_in1", {32'h0, sub_in1}, 64'h0);
        checkOutput("reset sub_in2", {32'h0, sub_in2}, 64'h0);
        checkOutput("reset ready", {62'h0, req1_ready, req0_ready}, 64'h0);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;

        $display("[TB] single-requester vectors");
        applyStimulus(1'b0, 32'd5, 32'd3, 36'h0_00000002);
        applyStimulus(1'b0, 32'd3, 32'd5, 36'h8_FFFFFFFE);
        applyStimulus(1'b1, 32'd7, 32'd7, 36'h4_00000000);
        applyStimulus(1'b1, 32'h80000000, 32'd1, 36'h1_7FFFFFFF);
        modelC = 1'b1;
        applyStimulus(1'b0, 32'd1, 32'd2, 36'hA_FFFFFFFF);
        modelC = 1'b0;

        $display("[TB] contested round-robin");
        applyReset();
        @(posedge clock);
        #1;
        driveReq(1'b0, 32'd10, 32'd4);
        driveReq(1'b1, 32'd4, 32'd10);
        rsp_ready = 1'b1;
        grants    = 0;
        lastCycle = 0;
        for (int cyc = 0; cyc < 20 && grants < 4; cyc++) begin
            @(negedge clock);
            if (req0_ready || req1_ready) begin
                checkOutput("rr grant", {62'h0, req1_ready, req0_ready},
                            (grants % 2 == 0) ? 64'h1 : 64'h2);
                expQ.push_back((grants % 2 == 0) ? {1'b0, 36'h0_00000006} : {1'b1, 36'h8_FFFFFFFA});
                if (grants > 0) begin
                    checkOutput("rr spacing", 64'(cyc - lastCycle), 64'd3);
                end
                lastCycle = cyc;
                grants    = grants + 1;
            end
        end
        @(posedge clock);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("rr grant count", 64'(grants), 64'd4);
        repeat (4) @(negedge clock);

        $display("[TB] response backpressure");
        @(posedge clock);
        #1;
        driveReq(1'b0, 32'd9, 32'd2);
        rsp_ready = 1'b0;
        @(negedge clock);
        checkOutput("hold grant", {63'h0, req0_ready}, 64'h1);
        expQ.push_back({1'b0, 36'h0_00000007});
        @(posedge clock);
        #1;
        req0_valid = 1'b0;
        driveReq(1'b1, 32'd20, 32'd5);
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold rsp_valid", {63'h0, rsp_valid}, 64'h1);
            checkOutput("hold rsp_data", {28'h0, rsp_data}, {28'h0, 36'h0_00000007});
            checkOutput("hold rsp_id", {63'h0, rsp_id}, 64'h0);
            checkOutput("hold ready", {62'h0, req1_ready, req0_ready}, 64'h0);
            checkOutput("hold sub_en", {63'h0, sub_en}, 64'h0);
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkOutput("hold release grant", {62'h0, req1_ready, req0_ready}, 64'h2);
        expQ.push_back({1'b1, 36'h0_0000000F});
        @(posedge clock);
        #1;
        req1_valid = 1'b0;
        repeat (4) @(negedge clock);

        $display("[TB] reset during EXEC");
        @(posedge clock);
        #1;
        driveReq(1'b0, 32'd100, 32'd1);
        @(negedge clock);
        checkOutput("abort grant", {63'h0, req0_ready}, 64'h1);
        @(posedge clock);
        #1;
        req0_valid = 1'b0;
        @(negedge clock);
        checkOutput("abort exec sub_en", {63'h0, sub_en}, 64'h1);
        #2;
        clear = 1'b0;
        #1;
        checkOutput("abort sub_en", {63'h0, sub_en}, 64'h0);
        checkOutput("abort rsp_valid", {63'h0, rsp_valid}, 64'h0);
        checkOutput("abort rsp_data", {28'h0, rsp_data}, 64'h0);
        checkOutput("abort sub_in1", {32'h0, sub_in1}, 64'h0);
        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("abort no rsp", {63'h0, rsp_valid}, 64'h0);
        end
        applyStimulus(1'b1, 32'd12, 32'd5, 36'h0_00000007);

        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 20) begin
            @(negedge clock);
            waitCycles = waitCycles + 1;
        end
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun + monTests, testsFailed + monFailed);
        $finish;
    end

endmodule
